// File: rtl/axi_traffic_gen_chk.sv
// rtl/axi_traffic_gen_chk.sv - AXI4 write-then-readback traffic generator and checker
// Optional timeout watchdog is enabled by defining AXI_TG_TIMEOUT_EN.
module axi_traffic_gen_chk #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                ID_W       = 4,
  parameter logic [ID_W-1:0]   ID_VAL     = '0,
  parameter int                BURST_LEN  = 16,
  parameter int                NUM_BURSTS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]       SEED       = 32'hA5A5_0000
`ifdef AXI_TG_TIMEOUT_EN
  , parameter int              TIMEOUT_CYC = 1024
`endif
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
`ifdef AXI_TG_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  localparam int          BEAT_BYTES = DATA_W / 8;
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
  localparam logic [8:0]  LAST_BEAT  = 9'(BURST_LEN - 1);

  state_t              r_state, w_next;
  logic [15:0]         r_burst_cnt;
  logic [8:0]          r_beat_cnt;
  logic [15:0]         r_err_cnt;
  logic [ADDR_W-1:0]   w_burst_addr, w_beat_addr;
  logic [DATA_W-1:0]   w_pattern;
  logic                w_last_beat, w_more, w_start, w_to_hit;
  logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_r_end, w_err;
  logic                w_unused_rid;

  assign w_burst_addr = BASE_ADDR + ADDR_W'(r_burst_cnt) * ADDR_W'(BURST_LEN * BEAT_BYTES);
  assign w_beat_addr  = w_burst_addr + ADDR_W'(r_beat_cnt) * ADDR_W'(BEAT_BYTES);
  assign w_pattern    = DATA_W'(w_beat_addr) ^ {(DATA_W/32){SEED}};
  assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
  assign w_more       = (r_burst_cnt != LAST_BURST);
  assign w_start      = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_aw_hs = (r_state == S_AW) && m_axi_awready;
  assign w_w_hs  = (r_state == S_W)  && m_axi_wready;
  assign w_b_hs  = (r_state == S_B)  && m_axi_bvalid;
  assign w_ar_hs = (r_state == S_AR) && m_axi_arready;
  assign w_r_hs  = (r_state == S_R)  && m_axi_rvalid;
  // An early rlast ends the burst; the rlast mismatch itself is the one error counted.
  assign w_r_end = w_r_hs && (m_axi_rlast || w_last_beat);
  assign w_err   = (w_b_hs && ((m_axi_bresp != 2'b00) || (m_axi_bid != ID_VAL))) ||
                   (w_r_hs && ((m_axi_rdata != w_pattern) || (m_axi_rresp != 2'b00) ||
                               (m_axi_rlast != w_last_beat)));
  assign w_unused_rid = ^m_axi_rid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)         w_next = S_AW;
      S_AW:           if (m_axi_awready) w_next = S_W;
      S_W:            if (m_axi_wready && w_last_beat) w_next = S_B;
      S_B:            if (m_axi_bvalid)  w_next = w_more ? S_AW : S_AR;
      S_AR:           if (m_axi_arready) w_next = S_R;
      S_R:            if (w_r_end)       w_next = w_more ? S_AR : S_DONE;
      default:                           w_next = S_IDLE;
    endcase
    if (w_to_hit) w_next = S_DONE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_err_cnt   <= '0;
    end else if (w_start) begin
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      if (w_w_hs || w_r_hs) r_beat_cnt <= (w_last_beat || w_r_end) ? 9'd0 : r_beat_cnt + 9'd1;
      if (w_b_hs || w_r_end) r_burst_cnt <= w_more ? r_burst_cnt + 16'd1 : 16'd0;
    end
  end

`ifdef AXI_TG_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;
  logic        w_any_hs;

  assign w_any_hs = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;
  // Compare against TIMEOUT_CYC-1 so DONE is entered exactly TIMEOUT_CYC idle cycles in.
  assign w_to_hit = busy && (r_to_cnt == 16'(TIMEOUT_CYC - 1));
  assign timeout  = r_timeout;
  assign pass     = done && (r_err_cnt == 16'd0) && !r_timeout;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt <= (w_any_hs || !busy) ? 16'd0 : r_to_cnt + 16'd1;
      if (w_to_hit) r_timeout <= 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
  assign pass     = done && (r_err_cnt == 16'd0);
`endif

  assign busy    = r_state inside {S_AW, S_W, S_B, S_AR, S_R};
  assign done    = (r_state == S_DONE);
  assign err_cnt = r_err_cnt;

  assign m_axi_awid    = ID_VAL;
  assign m_axi_awaddr  = w_burst_addr;
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (r_state == S_AW);
  assign m_axi_wdata   = w_pattern;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_last_beat;
  assign m_axi_wvalid  = (r_state == S_W);
  assign m_axi_bready  = (r_state == S_B);
  assign m_axi_arid    = ID_VAL;
  assign m_axi_araddr  = w_burst_addr;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (r_state == S_AR);
  assign m_axi_rready  = (r_state == S_R);

endmodule

// File: tb/tb_axi_traffic_gen_chk.sv
// tb/tb_axi_traffic_gen_chk.sv - randomized self-checking bench for axi_traffic_gen_chk
module tb_axi_traffic_gen_chk;
  localparam int          L    = 16;
  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, wlast, arvalid, bready, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;
  logic [3:0]  bid = 4'd0, rid = 4'd0;

  int          checks = 0, errors = 0;
  int unsigned cyc = 0;
  bit          bp_en = 0, corrupt_en = 0, early_en = 0;
  int          slverr_idx = -1, exp_err = 0;
  int          aw_n = 0, ar_n = 0, w_burst = 0, w_beat = 0;
  logic [31:0] first_aw = '0, last_ar = '0, first_wd = '0;

  axi_traffic_gen_chk #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .ID_VAL(4'd0), .BURST_LEN(L),
    .NUM_BURSTS(N), .BASE_ADDR(BASE), .SEED(SEED)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int burst);
    return BASE + 32'(burst) * 32'(L * 4);
  endfunction

  function automatic logic [31:0] exp_data(input int burst, input int beat);
    return (exp_addr(burst) + 32'(beat * 4)) ^ SEED;
  endfunction

  // Memory slave: random readiness when bp_en, plus fault injection knobs.
  initial begin
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wr_addr, rd_addr, a, s_awaddr, s_araddr, s_wdata;
    logic        s_awv, s_wv, s_wl, s_arv, s_bready, s_rready;
    int          wr_beat, rd_beat, wr_n, rd_n, cur_wr, cur_rd;
    bit          b_pend, r_act;
    wr_addr = '0; rd_addr = '0; wr_beat = 0; rd_beat = 0; wr_n = 0; rd_n = 0;
    cur_wr = 0; cur_rd = 0; b_pend = 0; r_act = 0;
    s_awv = 0; s_wv = 0; s_wl = 0; s_arv = 0; s_bready = 0; s_rready = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0;
    forever begin
      @(negedge aclk); #1;
      if (!aresetn) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
        bresp = 2'b00; rresp = 2'b00; rdata = '0;
        b_pend = 0; r_act = 0; wr_n = 0; rd_n = 0;
        s_awv = 0; s_wv = 0; s_wl = 0; s_arv = 0; s_bready = 0; s_rready = 0;
      end else begin
        if (s_awv && awready) begin wr_addr = s_awaddr; wr_beat = 0; cur_wr = wr_n % N; wr_n++; end
        if (s_wv && wready) begin
          mem[wr_addr + 32'(wr_beat * 4)] = s_wdata;
          wr_beat++;
          if (s_wl) b_pend = 1;
        end
        if (bvalid && s_bready) bvalid = 0;
        if (s_arv && arready) begin rd_addr = s_araddr; rd_beat = 0; cur_rd = rd_n % N; rd_n++; r_act = 1; end
        if (rvalid && s_rready) begin
          rvalid = 0;
          rd_beat++;
          if (rlast) r_act = 0;
        end
        awready = bp_en ? ($urandom_range(9, 0) >= 3) : 1'b1;
        wready  = bp_en ? ($urandom_range(9, 0) >= 3) : 1'b1;
        arready = bp_en ? ($urandom_range(9, 0) >= 3) : 1'b1;
        if (b_pend && !bvalid && (!bp_en || $urandom_range(9, 0) >= 3)) begin
          bvalid = 1;
          bresp  = (cur_wr == slverr_idx) ? 2'b10 : 2'b00;
          b_pend = 0;
        end
        if (r_act && !rvalid && (!bp_en || $urandom_range(9, 0) >= 3)) begin
          a = rd_addr + 32'(rd_beat * 4);
          rdata = mem.exists(a) ? mem[a] : 32'h0;
          if (corrupt_en && (cur_rd == 2 || cur_rd == 5) && rd_beat == 3) rdata = rdata ^ 32'h1;
          rlast  = (rd_beat == L - 1) || (early_en && cur_rd == 0 && rd_beat == 4);
          rresp  = 2'b00;
          rvalid = 1;
        end
        s_awv = awvalid; s_awaddr = awaddr; s_wv = wvalid; s_wdata = wdata; s_wl = wlast;
        s_arv = arvalid; s_araddr = araddr; s_bready = bready; s_rready = rready;
      end
    end
  end

  // Compare process: model of expected AXI traffic and completion status.
  initial begin
    logic        p_awv, p_wv, p_wl, p_arv, p_busy, p_done, p_rst;
    logic [31:0] p_awaddr, p_araddr, p_wdata;
    logic [16:0] p_awctl, p_arctl;
    logic [3:0]  p_wstrb;
    p_awv = 0; p_wv = 0; p_wl = 0; p_arv = 0; p_busy = 0; p_done = 0; p_rst = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_awctl = '0; p_arctl = '0; p_wstrb = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        chk("reset_outputs", 64'({awvalid, wvalid, arvalid, bready, rready, busy, done, pass, err_cnt}), 64'd0);
        p_awv = 0; p_wv = 0; p_arv = 0; p_busy = 0; p_done = 0; p_rst = 1;
        aw_n = 0; ar_n = 0; w_burst = 0; w_beat = 0;
      end else begin
        if (p_rst)
          chk("post_reset_outputs", 64'({awvalid, wvalid, arvalid, bready, rready, busy, done, pass, err_cnt}), 64'd0);
        p_rst = 0;
        if (start && !p_busy) begin aw_n = 0; ar_n = 0; w_burst = 0; w_beat = 0; end
        if (p_awv && awready) begin
          chk("awaddr", 64'(p_awaddr), 64'(exp_addr(aw_n)));
          chk("aw_ctrl", 64'(p_awctl), 64'({4'd0, 8'(L - 1), 3'd2, 2'b01}));
          if (aw_n == 0) first_aw = p_awaddr;
          aw_n++;
        end
        if (p_wv && wready) begin
          chk("wdata", 64'(p_wdata), 64'(exp_data(w_burst, w_beat)));
          chk("wlast", 64'(p_wl), 64'(w_beat == L - 1));
          chk("wstrb", 64'(p_wstrb), 64'hF);
          if (w_burst == 0 && w_beat == 0) first_wd = p_wdata;
          if (w_beat == L - 1) begin w_beat = 0; w_burst++; end
          else w_beat++;
        end
        if (p_arv && arready) begin
          chk("araddr", 64'(p_araddr), 64'(exp_addr(ar_n)));
          chk("ar_ctrl", 64'(p_arctl), 64'({4'd0, 8'(L - 1), 3'd2, 2'b01}));
          last_ar = p_araddr;
          ar_n++;
        end
        if (p_awv && !awready) chk("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
        if (p_arv && !arready) chk("ar_stable", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
        if (p_wv && !wready) chk("w_stable", 64'({wvalid, wlast, wdata}), 64'({1'b1, p_wl, p_wdata}));
        if (wvalid) chk("w_after_aw", 64'(aw_n), 64'(w_burst + 1));
        if (arvalid && !p_arv) chk("ar_after_writes", 64'(w_burst), 64'(N));
        if (done && !p_done) begin
          chk("err_at_done", 64'(err_cnt), 64'(exp_err));
          chk("pass_at_done", 64'(pass), 64'(exp_err == 0));
          chk("busy_at_done", 64'(busy), 64'd0);
          chk("aw_count", 64'(aw_n), 64'(N));
          chk("ar_count", 64'(ar_n), 64'(N));
        end
        p_awv = awvalid; p_awaddr = awaddr; p_awctl = {awid, awlen, awsize, awburst};
        p_arv = arvalid; p_araddr = araddr; p_arctl = {arid, arlen, arsize, arburst};
        p_wv = wvalid; p_wdata = wdata; p_wl = wlast; p_wstrb = wstrb;
        p_busy = busy; p_done = done;
      end
    end
  end

  task automatic run(input bit mid_start, output int lat);
    int unsigned t0;
    int n;
    @(negedge aclk); #3 start = 1; t0 = cyc;
    @(negedge aclk); #3 start = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_cleared", 64'(done), 64'd0);
    n = 0;
    lat = 0;
    while (!done && n < 20000) begin
      @(negedge aclk);
      n++;
      if (mid_start && n == 40) begin
        #3 start = 1;
        @(negedge aclk); #3 start = 0;
        n++;
      end
    end
    chk("done_reached", 64'(done), 64'd1);
    lat = int'(cyc - t0);
    chk("pass", 64'(pass), 64'(exp_err == 0));
    chk("err_cnt", 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    int lat, n;
    repeat (3) @(negedge aclk);
    #3 aresetn = 1;
    repeat (2) @(negedge aclk);

    exp_err = 0;
    run(0, lat);
    chk("latency", 64'(lat), 64'(N * (2 * L + 3) + 1));
    chk("first_awaddr", 64'(first_aw), 64'h1000);
    chk("last_araddr", 64'(last_ar), 64'h11C0);
    chk("first_wdata", 64'(first_wd), 64'hA5A51000);

    bp_en = 1;
    run(1, lat);

    corrupt_en = 1; exp_err = 2;
    run(0, lat);
    corrupt_en = 0;

    slverr_idx = 6; exp_err = 1;
    run(0, lat);
    slverr_idx = -1;

    bp_en = 0; early_en = 1; exp_err = 1;
    run(0, lat);
    early_en = 0;

    bp_en = 1; exp_err = 0;
    @(negedge aclk); #3 start = 1;
    @(negedge aclk); #3 start = 0;
    n = 0;
    while (!(wvalid && w_burst == 3 && w_beat >= 2) && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    chk("reached_w_burst3", 64'(wvalid), 64'd1);
    #3 aresetn = 0;
    repeat (3) @(negedge aclk);
    #3 aresetn = 1;
    repeat (2) @(negedge aclk);
    run(0, lat);
    chk("restart_awaddr", 64'(first_aw), 64'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
